// File: rtl/inst_align_pkg.sv
// Shared decode types for the instruction aligner and the decode select path.
// Holds the aligner state encoding, the output bundle and the RVC test.
package inst_align_pkg;

    localparam int unsigned ILEN = 32;
    localparam int unsigned HLEN = 16;
    localparam int unsigned XLEN = 64;

    // Byte increments applied to the halfword PC.
    localparam logic [XLEN-1:0] PC_INC_HALF = 64'd2;
    localparam logic [XLEN-1:0] PC_INC_WORD = 64'd4;

    typedef enum logic [1:0] {
        ALIGN_EMPTY = 2'd0,
        ALIGN_HALF  = 2'd1,
        ALIGN_SKIP  = 2'd2
    } align_state_e;

    // Output register bundle presented to decode.
    typedef struct packed {
        logic            valid;
        logic [ILEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic            rvc;
    } align_out_t;

    localparam align_out_t ALIGN_OUT_RST = '{
        valid: 1'b0,
        inst:  '0,
        pc:    '0,
        rvc:   1'b0
    };

    // Any halfword whose two low bits are not 2'b11 is a compressed insn.
    function automatic logic is_rvc(input logic [HLEN-1:0] h);
        return h[1:0] != 2'b11;
    endfunction

    // Build a valid output entry; the compressed flag follows the
    // instruction's own low bits so it always matches id_inst.
    function automatic align_out_t mk_out(
        input logic [ILEN-1:0] inst,
        input logic [XLEN-1:0] pc
    );
        align_out_t o;
        o.valid = 1'b1;
        o.inst  = inst;
        o.pc    = pc;
        o.rvc   = is_rvc(inst[HLEN-1:0]);
        return o;
    endfunction

    // Zero-extend a compressed halfword to instruction width.
    function automatic logic [ILEN-1:0] rvc_inst(input logic [HLEN-1:0] h);
        return {{(ILEN-HLEN){1'b0}}, h};
    endfunction

endpackage

// File: rtl/inst_align.sv
// Instruction aligner: splits 32-bit fetch words into RVC and 32-bit insns.
// Ports: clk/rst_n, if_* fetch handshake, flush/flush_pc, id_* decode output.
module inst_align
    import inst_align_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] if_data,

    input  logic        flush,
    input  logic [63:0] flush_pc,

    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [63:0] id_pc,
    output logic        compressed
);

    align_state_e    state_q, state_d;
    logic [HLEN-1:0] hbuf_q, hbuf_d;
    logic [XLEN-1:0] next_pc_q, next_pc_d;
    align_out_t      out_q, out_d;

    logic            out_free;
    logic            rdy_c;
    logic [HLEN-1:0] lo_h;
    logic [HLEN-1:0] hi_h;

    assign lo_h = if_data[HLEN-1:0];
    assign hi_h = if_data[ILEN-1:HLEN];

    // The output slot can take a new entry if empty or being drained now.
    assign out_free = !out_q.valid || id_ready;

    always_comb begin
        state_d   = state_q;
        hbuf_d    = hbuf_q;
        next_pc_d = next_pc_q;
        out_d     = out_q;
        rdy_c     = 1'b0;

        if (flush) begin
            // Redirect: drop the held insn and any buffered halfword.
            out_d.valid = 1'b0;
            next_pc_d   = flush_pc;
            state_d     = flush_pc[1] ? ALIGN_SKIP : ALIGN_EMPTY;
        end else begin
            if (out_q.valid && id_ready) begin
                out_d.valid = 1'b0;
            end

            if (out_free) begin
                unique case (state_q)
                    ALIGN_EMPTY: begin
                        rdy_c = 1'b1;
                        if (if_valid) begin
                            if (is_rvc(lo_h)) begin
                                out_d     = mk_out(rvc_inst(lo_h), next_pc_q);
                                hbuf_d    = hi_h;
                                state_d   = ALIGN_HALF;
                                next_pc_d = next_pc_q + PC_INC_HALF;
                            end else begin
                                out_d     = mk_out(if_data, next_pc_q);
                                next_pc_d = next_pc_q + PC_INC_WORD;
                            end
                        end
                    end

                    ALIGN_HALF: begin
                        if (is_rvc(hbuf_q)) begin
                            // Buffered RVC issues without a fetch.
                            out_d     = mk_out(rvc_inst(hbuf_q), next_pc_q);
                            state_d   = ALIGN_EMPTY;
                            next_pc_d = next_pc_q + PC_INC_HALF;
                        end else begin
                            rdy_c = 1'b1;
                            if (if_valid) begin
                                // Straddling 32-bit insn: hbuf is the low half.
                                out_d     = mk_out({lo_h, hbuf_q}, next_pc_q);
                                hbuf_d    = hi_h;
                                next_pc_d = next_pc_q + PC_INC_WORD;
                            end
                        end
                    end

                    ALIGN_SKIP: begin
                        // Redirect landed on the upper halfword; the low
                        // half of this word precedes the target.
                        rdy_c = 1'b1;
                        if (if_valid) begin
                            hbuf_d  = hi_h;
                            state_d = ALIGN_HALF;
                        end
                    end

                    default: begin
                        state_d = ALIGN_EMPTY;
                    end
                endcase
            end
        end
    end

    // Held low while in reset so fetch never sees a spurious accept.
    assign if_ready = rdy_c && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ALIGN_EMPTY;
            hbuf_q    <= '0;
            next_pc_q <= RESET_PC;
            out_q     <= ALIGN_OUT_RST;
        end else begin
            state_q   <= state_d;
            hbuf_q    <= hbuf_d;
            next_pc_q <= next_pc_d;
            out_q     <= out_d;
        end
    end

    assign id_valid   = out_q.valid;
    assign id_inst    = out_q.inst;
    assign id_pc      = out_q.pc;
    assign compressed = out_q.rvc;

endmodule
